// File: rtl/lfsr_encrypt_pad.sv
// Memory-mastering encryptor: pads a message with leading spaces, whitens it with a
// 7-bit LFSR keystream and writes a 64-byte even-parity image to the upper memory half.
module lfsr_encrypt_pad #(
    parameter int unsigned PARAM_BASE = 61,
    parameter int unsigned OUT_BASE   = 64,
    parameter int unsigned NUM_BYTES  = 64
) (
    input  logic       clk,
    input  logic       init,
    input  logic       req,
    output logic       ack,
    output logic [7:0] mem_addr,
    output logic       mem_rd_en,
    input  logic [7:0] mem_rdata,
    output logic       mem_wr_en,
    output logic [7:0] mem_wdata
);

    localparam logic [7:0] PRE_ADDR  = 8'(PARAM_BASE);
    localparam logic [7:0] TAPS_ADDR = 8'(PARAM_BASE + 1);
    localparam logic [7:0] SEED_ADDR = 8'(PARAM_BASE + 2);
    localparam logic [7:0] OUT_ADDR  = 8'(OUT_BASE);
    localparam logic [7:0] LAST_IDX  = 8'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LD0, ST_LD1, ST_LD2, ST_LD3, ST_RD, ST_WR, ST_DONE
    } state_t;

    function automatic logic parity7(input logic [6:0] v);
        return ^v;
    endfunction

    state_t      state_r;
    state_t      state_nx_s;
    logic        req_q_r;
    logic        ack_r;
    logic [7:0]  idx_r;
    logic [3:0]  pre_r;
    logic [6:0]  taps_r;
    logic [6:0]  lfsr_r;

    logic        start_s;
    logic        pad_s;
    logic [7:0]  plain_s;
    logic [6:0]  offset_s;
    logic [6:0]  cipher_lo_s;
    logic [7:0]  cipher_s;
    logic        feedback_s;
    logic [3:0]  pre_clamp_s;
    logic [6:0]  seed_fix_s;

    assign start_s     = req_q_r & ~req;
    assign pad_s       = (idx_r < {4'd0, pre_r});
    assign plain_s     = pad_s ? 8'h20 : mem_rdata;
    // Modulo-128 offset: 0x20..0x9F folds onto 0x00..0x7F.
    assign offset_s    = 7'(plain_s - 8'h20);
    assign cipher_lo_s = offset_s ^ lfsr_r;
    assign cipher_s    = {parity7(cipher_lo_s), cipher_lo_s};
    assign feedback_s  = ^(lfsr_r & taps_r);
    assign pre_clamp_s = (mem_rdata[3:0] < 4'd10) ? 4'd10 : mem_rdata[3:0];
    assign seed_fix_s  = (mem_rdata[6:0] == 7'd0) ? 7'd1 : mem_rdata[6:0];
    assign ack         = ack_r;

    // Next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) state_nx_s = ST_LD0;
                else         state_nx_s = ST_IDLE;
            end
            ST_LD0:  state_nx_s = ST_LD1;
            ST_LD1:  state_nx_s = ST_LD2;
            ST_LD2:  state_nx_s = ST_LD3;
            ST_LD3:  state_nx_s = ST_RD;
            ST_RD:   state_nx_s = ST_WR;
            ST_WR: begin
                if (idx_r == LAST_IDX) state_nx_s = ST_DONE;
                else                   state_nx_s = ST_RD;
            end
            ST_DONE: begin
                if (start_s) state_nx_s = ST_LD0;
                else         state_nx_s = ST_DONE;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Memory strobes decoded from state; write data follows read data by one cycle.
    always_comb begin
        mem_addr  = 8'd0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_wdata = 8'd0;
        case (state_r)
            ST_LD0: begin
                mem_addr  = PRE_ADDR;
                mem_rd_en = 1'b1;
            end
            ST_LD1: begin
                mem_addr  = TAPS_ADDR;
                mem_rd_en = 1'b1;
            end
            ST_LD2: begin
                mem_addr  = SEED_ADDR;
                mem_rd_en = 1'b1;
            end
            ST_RD: begin
                if (!pad_s) begin
                    mem_addr  = idx_r - {4'd0, pre_r};
                    mem_rd_en = 1'b1;
                end else begin
                    mem_addr  = 8'd0;
                    mem_rd_en = 1'b0;
                end
            end
            ST_WR: begin
                mem_addr  = OUT_ADDR + idx_r;
                mem_wr_en = 1'b1;
                mem_wdata = cipher_s;
            end
            default: begin
                mem_addr  = 8'd0;
                mem_rd_en = 1'b0;
            end
        endcase
    end

    // State, parameter capture, keystream and index registers.
    always_ff @(posedge clk) begin
        if (!init) begin
            state_r <= ST_IDLE;
            req_q_r <= 1'b0;
            ack_r   <= 1'b0;
            idx_r   <= 8'd0;
            pre_r   <= 4'd0;
            taps_r  <= 7'd0;
            lfsr_r  <= 7'd0;
        end else begin
            state_r <= state_nx_s;
            req_q_r <= req;
            // ack trails DONE by one edge and drops on the restart edge.
            ack_r   <= (state_r == ST_DONE) && !start_s;
            case (state_r)
                ST_LD1: pre_r  <= pre_clamp_s;
                ST_LD2: taps_r <= mem_rdata[6:0];
                ST_LD3: begin
                    lfsr_r <= seed_fix_s;
                    idx_r  <= 8'd0;
                end
                ST_WR: begin
                    lfsr_r <= {lfsr_r[5:0], feedback_s};
                    idx_r  <= idx_r + 8'd1;
                end
                default: begin
                    lfsr_r <= lfsr_r;
                    idx_r  <= idx_r;
                end
            endcase
        end
    end

endmodule
